// File: rtl/multi_button_conditioner.sv
`default_nettype none
//==============================================================================
// Module   : multi_button_conditioner
// Brief    : Per-channel synchroniser, debouncer and press/release/long/repeat
//            pulse generator for active-low push-buttons.
// Revision : 1.0 - initial release
//==============================================================================
module multi_button_conditioner #(
  parameter int NUM_BUTTONS     = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 20,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic                   not_clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] btn_n,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] long_pulse,
  output logic [NUM_BUTTONS-1:0] held
);

  localparam int c_dbc_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_hold_max = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int c_hc_w     = $clog2(c_hold_max + 1);

  localparam logic [c_dbc_w-1:0] c_dbc_last = c_dbc_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_dbc_w-1:0] c_dbc_one  = c_dbc_w'(1);
  localparam logic [c_hc_w-1:0]  c_long_last = c_hc_w'(LONG_CYCLES - 1);
  localparam logic [c_hc_w-1:0]  c_rep_last  = c_hc_w'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [c_hc_w-1:0]  c_hc_one    = c_hc_w'(1);
  localparam logic [c_hc_w-1:0]  c_hc_sat    = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] r_sync;
      logic [c_dbc_w-1:0]     r_dbc;
      logic                   r_db;
      state_t                 r_state;
      state_t                 w_state_nxt;
      logic [c_hc_w-1:0]      r_hc;
      logic [c_hc_w-1:0]      w_hc_nxt;
      logic                   w_sync_out;
      logic                   w_press;
      logic                   w_release;
      logic                   w_long;
      logic                   r_press;
      logic                   r_release;
      logic                   r_long;
      logic                   r_held;

      assign w_sync_out = r_sync[SYNC_STAGES-1];

      // Debounced level only moves after DEBOUNCE_CYCLES consecutive disagreements
      always_ff @(posedge not_clk) begin
        if (rst) begin
          r_sync <= '1;
          r_dbc  <= '0;
          r_db   <= 1'b1;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], btn_n[gi]};
          if (w_sync_out == r_db) begin
            r_dbc <= '0;
          end else if (r_dbc == c_dbc_last) begin
            r_db  <= w_sync_out;
            r_dbc <= '0;
          end else begin
            r_dbc <= r_dbc + c_dbc_one;
          end
        end
      end

      // In IDLE db is 1 unless it just fell; outside IDLE it is 0 unless it just rose
      always_comb begin
        w_state_nxt = r_state;
        w_hc_nxt    = r_hc;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_long      = 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (!r_db) begin
              w_press     = 1'b1;
              w_hc_nxt    = '0;
              w_state_nxt = ST_PRESSED;
            end
          end
          ST_PRESSED: begin
            if (r_db) begin
              w_release   = 1'b1;
              w_state_nxt = ST_IDLE;
            end else if (r_hc == c_long_last) begin
              w_long      = 1'b1;
              w_hc_nxt    = '0;
              w_state_nxt = ST_LONG;
            end else begin
              w_hc_nxt = r_hc + c_hc_one;
            end
          end
          ST_LONG: begin
            if (r_db) begin
              w_release   = 1'b1;
              w_state_nxt = ST_IDLE;
            end else if (REPEAT_CYCLES > 0) begin
              if (r_hc == c_rep_last) begin
                w_press  = 1'b1;
                w_hc_nxt = '0;
              end else begin
                w_hc_nxt = r_hc + c_hc_one;
              end
            end else if (r_hc != c_hc_sat) begin
              w_hc_nxt = r_hc + c_hc_one;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_hc_nxt    = '0;
          end
        endcase
      end

      always_ff @(posedge not_clk) begin
        if (rst) begin
          r_state   <= ST_IDLE;
          r_hc      <= '0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
          r_long    <= 1'b0;
          r_held    <= 1'b0;
        end else begin
          r_state   <= w_state_nxt;
          r_hc      <= w_hc_nxt;
          r_press   <= w_press;
          r_release <= w_release;
          r_long    <= w_long;
          r_held    <= (w_state_nxt != ST_IDLE);
        end
      end

      assign press_pulse[gi]   = r_press;
      assign release_pulse[gi] = r_release;
      assign long_pulse[gi]    = r_long;
      assign held[gi]          = r_held;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_button_conditioner.sv
`default_nettype none
//==============================================================================
// Module   : tb_multi_button_conditioner
// Brief    : Self-checking bench; event-time reference model for a default
//            instance and an auto-repeat (period 5) instance.
// Revision : 1.0 - initial release
//==============================================================================
module tb_multi_button_conditioner;

  localparam int NB    = 3;
  localparam int SS    = 2;
  localparam int DB    = 4;
  localparam int LONG  = 20;
  localparam int REP_B = 5;

  logic          not_clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] press_pulse, release_pulse, long_pulse, held;
  logic [NB-1:0] press_r, release_r, long_r, held_r;

  int total = 0;
  int bad   = 0;

  always #5 not_clk = ~not_clk;

  multi_button_conditioner #(
    .NUM_BUTTONS(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LONG), .REPEAT_CYCLES(0)
  ) dut (
    .not_clk(not_clk), .rst(rst), .btn_n(btn_n),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .held(held)
  );

  multi_button_conditioner #(
    .NUM_BUTTONS(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP_B)
  ) dut_r (
    .not_clk(not_clk), .rst(rst), .btn_n(btn_n),
    .press_pulse(press_r), .release_pulse(release_r),
    .long_pulse(long_r), .held(held_r)
  );

  logic [8*NB-1:0] act;
  assign act = {held_r, long_r, release_r, press_r, held, long_pulse, release_pulse, press_pulse};

  // Reference model: an accepted level change happens once the last DB synchronised
  // samples all disagree with the accepted level; events follow one edge later, and
  // long/repeat pulses are placed by elapsed time since the press.
  logic [NB-1:0] hist[$];
  logic          m_db      [2][NB];
  bit            m_pend    [2][NB];
  bit            m_pressed [2][NB];
  int            m_tpress  [2][NB];
  logic [NB-1:0] e_press[2], e_rel[2], e_long[2], e_held[2];
  logic [8*NB-1:0] exp_v;
  int            edge_n = 0;
  bit            all_diff;
  int            d, rp;

  always @(posedge not_clk) begin
    if (rst) begin
      hist.delete();
      for (int i = 0; i < SS + DB; i++) hist.push_back('1);
      for (int k = 0; k < 2; k++) begin
        e_press[k] = '0; e_rel[k] = '0; e_long[k] = '0; e_held[k] = '0;
        for (int c = 0; c < NB; c++) begin
          m_db[k][c] = 1'b1; m_pend[k][c] = 0; m_pressed[k][c] = 0; m_tpress[k][c] = 0;
        end
      end
    end else begin
      hist.push_back(btn_n);
      void'(hist.pop_front());
      for (int k = 0; k < 2; k++) begin
        rp = (k == 0) ? 0 : REP_B;
        for (int c = 0; c < NB; c++) begin
          e_press[k][c] = 1'b0; e_rel[k][c] = 1'b0; e_long[k][c] = 1'b0;
          if (m_pend[k][c]) begin
            if (!m_db[k][c]) begin
              e_press[k][c] = 1'b1; m_pressed[k][c] = 1; m_tpress[k][c] = edge_n;
            end else begin
              e_rel[k][c] = 1'b1; m_pressed[k][c] = 0;
            end
          end else if (m_pressed[k][c]) begin
            d = edge_n - m_tpress[k][c];
            if (d == LONG) e_long[k][c] = 1'b1;
            else if (rp > 0 && d > LONG && ((d - LONG) % rp) == 0) e_press[k][c] = 1'b1;
          end
          e_held[k][c] = m_pressed[k][c];
          all_diff = 1;
          for (int i = 0; i < DB; i++) if (hist[i][c] == m_db[k][c]) all_diff = 0;
          m_pend[k][c] = all_diff;
          if (all_diff) m_db[k][c] = ~m_db[k][c];
        end
      end
    end
    exp_v = {e_held[1], e_long[1], e_rel[1], e_press[1], e_held[0], e_long[0], e_rel[0], e_press[0]};
    edge_n++;
  end

  task automatic test_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge not_clk); btn_n = '1;
      @(posedge not_clk); #1;
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL idle_model cyc=%0d act=%h exp=%h", i, act, exp_v); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_n = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge not_clk); #1;
      total++;
      if (act !== '0) begin bad++; $display("FAIL reset_outputs cyc=%0d act=%h exp=0", i, act); end
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge not_clk); rst = 1'b0;
      @(posedge not_clk); #1;
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL reset_model cyc=%0d act=%h exp=%h", i, act, exp_v); end
      total++;
      if ({press_pulse, held} !== {(i + 1 == 7) ? 3'b111 : 3'b000, (i + 1 >= 7) ? 3'b111 : 3'b000}) begin
        bad++; $display("FAIL reset_first_press edge=%0d press=%b held=%b", i + 1, press_pulse, held);
      end
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 22; i++) begin
      @(negedge not_clk); btn_n = (i < 10) ? 3'b110 : 3'b111;
      @(posedge not_clk); #1;
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL single_model cyc=%0d act=%h exp=%h", i, act, exp_v); end
      total++;
      if ({press_pulse[0], release_pulse[0], long_pulse[0], held[0]} !==
          {i + 1 == 7, i + 1 == 17, 1'b0, (i + 1 >= 7) && (i + 1 < 17)}) begin
        bad++; $display("FAIL single_ch0 edge=%0d p/r/l/h=%b%b%b%b", i + 1,
                        press_pulse[0], release_pulse[0], long_pulse[0], held[0]);
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 30; i++) begin
      @(negedge not_clk);
      btn_n = (i >= 10 && i < 13) ? 3'b101 : 3'b111;
      if (i == 2) begin btn_n[1] = 1'b0; #1; btn_n[1] = 1'b1; end
      @(posedge not_clk); #1;
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL glitch_model cyc=%0d act=%h exp=%h", i, act, exp_v); end
      total++;
      if ({press_pulse[1], release_pulse[1], long_pulse[1], held[1],
           press_r[1], release_r[1], long_r[1], held_r[1]} !== 8'h00) begin
        bad++; $display("FAIL glitch_ch1 cyc=%0d p=%b r=%b l=%b h=%b", i,
                        press_pulse[1], release_pulse[1], long_pulse[1], held[1]);
      end
    end
  endtask

  task automatic test_bounce();
    int np_hold, nr_hold, nr_after;
    np_hold = 0; nr_hold = 0; nr_after = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge not_clk);
      btn_n = 3'b111;
      if (i < 6) btn_n[0] = i[0];
      else if (i < 30) btn_n[0] = 1'b0;
      @(posedge not_clk); #1;
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL bounce_model cyc=%0d act=%h exp=%h", i, act, exp_v); end
      if (i < 30) begin np_hold += press_pulse[0]; nr_hold += release_pulse[0]; end
      else nr_after += release_pulse[0];
    end
    total++;
    if ({np_hold, nr_hold, nr_after} !== {32'd1, 32'd0, 32'd1}) begin
      bad++; $display("FAIL bounce_counts press=%0d rel_held=%0d rel_after=%0d exp 1/0/1", np_hold, nr_hold, nr_after);
    end
  endtask

  task automatic test_long();
    for (int i = 0; i < 60; i++) begin
      @(negedge not_clk); btn_n = (i < 40) ? 3'b011 : 3'b111;
      @(posedge not_clk); #1;
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL long_model cyc=%0d act=%h exp=%h", i, act, exp_v); end
      total++;
      if ({press_pulse[2], long_pulse[2], release_pulse[2], held[2]} !==
          {i + 1 == 7, i + 1 == 27, i + 1 == 47, (i + 1 >= 7) && (i + 1 < 47)}) begin
        bad++; $display("FAIL long_ch2 edge=%0d p/l/r/h=%b%b%b%b", i + 1,
                        press_pulse[2], long_pulse[2], release_pulse[2], held[2]);
      end
    end
  endtask

  task automatic test_repeat();
    int e;
    for (int i = 0; i < 60; i++) begin
      @(negedge not_clk); btn_n = (i < 45) ? 3'b110 : 3'b111;
      @(posedge not_clk); #1;
      e = i + 1;
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL repeat_model cyc=%0d act=%h exp=%h", i, act, exp_v); end
      total++;
      if ({press_r[0], long_r[0], release_r[0], held_r[0]} !==
          {e == 7 || e == 32 || e == 37 || e == 42 || e == 47, e == 27, e == 52, (e >= 7) && (e < 52)}) begin
        bad++; $display("FAIL repeat_ch0 edge=%0d p/l/r/h=%b%b%b%b", e,
                        press_r[0], long_r[0], release_r[0], held_r[0]);
      end
      total++;
      if ({press_pulse[0], long_pulse[0], release_pulse[0]} !== {e == 7, e == 27, e == 52}) begin
        bad++; $display("FAIL norepeat_ch0 edge=%0d p/l/r=%b%b%b", e,
                        press_pulse[0], long_pulse[0], release_pulse[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 25; i++) begin
      @(negedge not_clk); btn_n = 3'b000; rst = (i == 15);
      @(posedge not_clk); #1;
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL rstmid_model cyc=%0d act=%h exp=%h", i, act, exp_v); end
      total++;
      if ({press_pulse, release_pulse} !== {(i == 6 || i == 22) ? 3'b111 : 3'b000, 3'b000}) begin
        bad++; $display("FAIL rstmid_pulses cyc=%0d press=%b rel=%b", i, press_pulse, release_pulse);
      end
    end
    @(negedge not_clk); rst = 1'b0;
  endtask

  task automatic test_random();
    logic [NB-1:0] lvl;
    lvl = '1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge not_clk);
      for (int c = 0; c < NB; c++) if ($urandom_range(0, 99) < 7) lvl[c] = ~lvl[c];
      btn_n = lvl;
      rst   = ($urandom_range(0, 399) == 0);
      @(posedge not_clk); #1;
      total++;
      if (act !== exp_v) begin bad++; $display("FAIL random_model cyc=%0d act=%h exp=%h", i, act, exp_v); end
    end
    @(negedge not_clk); rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle(20);
    test_single();
    test_idle(5);
    test_glitch();
    test_bounce();
    test_idle(5);
    test_long();
    test_idle(5);
    test_repeat();
    test_idle(5);
    test_reset_mid();
    test_idle(20);
    test_random();
    test_idle(30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_button_conditioner.md
Name: multi_button_conditioner

Overview:
- Parametrised, multi-channel successor to the single-button start/stop edge detector.
- Synchronises, debounces and edge-detects NUM_BUTTONS active-low push-buttons.
- Emits one-cycle press and release pulses and a long-press pulse, with optional auto-repeat while a button is held.
- Sits between the board buttons and the timer mode/control FSM. All outputs are registered and all channels are independent.

Parameters:
- NUM_BUTTONS, 3, number of independent button channels (>=1)
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change (>=1)
- LONG_CYCLES, 20, cycles after press_pulse before long_pulse fires (>=2)
- REPEAT_CYCLES, 0, auto-repeat period in LONG state; 0 disables auto-repeat

Ports:
- not_clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- btn_n  input  NUM_BUTTONS  raw asynchronous buttons, 0 = pressed
- press_pulse  output  NUM_BUTTONS  one-cycle pulse on accepted press, and on each auto-repeat
- release_pulse  output  NUM_BUTTONS  one-cycle pulse on accepted release
- long_pulse  output  NUM_BUTTONS  one-cycle pulse when a press has lasted LONG_CYCLES
- held  output  NUM_BUTTONS  high while a channel's FSM is not IDLE

Behaviour:
- Reset (rst=1 at a rising edge):
  - synchroniser flops and debounced level db are set to 1 (released).
  - All counters are cleared.
  - FSMs go to IDLE.
  - All outputs are 0 from the following cycle.
  - rst overrides all other activity.
- Synchroniser: per channel, a SYNC_STAGES-deep shift register; the last stage is sync_out.
- Debounce:
  - counter dbc, width $clog2(DEBOUNCE_CYCLES+1).
  - If sync_out==db, dbc is cleared to 0.
  - Otherwise dbc increments; when DEBOUNCE_CYCLES consecutive mismatching edges have occurred, db takes sync_out and dbc is cleared.
  - Pulses narrower than DEBOUNCE_CYCLES synchronised cycles, including sub-cycle glitches, are discarded.
- Per-channel FSM (IDLE, PRESSED, LONG) with hold counter hc, width $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1):
  - IDLE: when db goes 1->0, assert press_pulse for one cycle, clear hc, go to PRESSED.
  - PRESSED: hc increments each edge. When LONG_CYCLES edges have passed since press_pulse, assert long_pulse for one cycle, clear hc, go to LONG.
  - LONG, REPEAT_CYCLES>0: hc counts; every REPEAT_CYCLES edges, assert press_pulse for one cycle and clear hc.
  - LONG, REPEAT_CYCLES=0: hc saturates and no further pulses are produced.
  - PRESSED or LONG: when db goes 0->1, assert release_pulse for one cycle and go to IDLE.
- held = (state != IDLE), registered.
- Latency: press_pulse is high in the cycle after the (SYNC_STAGES+DEBOUNCE_CYCLES+1)-th rising edge, counting the first edge that samples btn_n low. This is 7 edges with defaults. Release latency is identical.
- Simultaneous events:
  - A release on the same edge as a long or repeat threshold: release wins; no long_pulse or press_pulse is emitted.
  - Channels pressed on the same edge pulse on the same cycle.
- Reset during a press: the channel returns to IDLE without a release_pulse. If the button is still low after rst falls, it is reported as a new press after the normal latency.
- No output pulse is ever wider than one cycle. press_pulse and release_pulse are never high together on the same channel.

Test Plan (defaults unless stated, 10 ns clock):
- rst=1 for 2 cycles with btn_n=3'b000 -> all outputs 0 during reset. After rst falls, press_pulse=3'b111 for exactly one cycle at the 7th edge, and held=3'b111.
- btn_n[0] low for 10 cycles, then high -> press_pulse[0] one cycle at edge 7; held[0] high from edge 7; release_pulse[0] one cycle 7 edges after release; long_pulse[0] never asserts.
- btn_n[1] low for 1 ns, then separately for 3 cycles -> no activity on any output of channel 1.
- btn_n[0] toggling every cycle for 6 cycles, then steady low -> exactly one press_pulse[0]; no release_pulse[0] until btn_n[0] returns high.
- btn_n[2] low for 40 cycles -> press_pulse[2] at edge 7, long_pulse[2] at edge 27, one release_pulse[2] after release, no other pulses.
- REPEAT_CYCLES=5, btn_n[0] low for 45 cycles -> press_pulse[0] at edges 7, 32, 37, 42, 47; long_pulse[0] at edge 27. Releasing on a repeat-threshold edge yields release_pulse only.
